// File: rtl/width_downsizer.sv
// width_downsizer: splits each IN_WIDTH input word into RATIO OUT_WIDTH chunks
// over valid/ready handshakes. A finishing word can be replaced by the next
// one in the same cycle, so throughput is one chunk per cycle.
module width_downsizer #(
  parameter int unsigned IN_WIDTH  = 20,
  parameter int unsigned OUT_WIDTH = 10,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic                 busy
);

  localparam int unsigned RATIO = IN_WIDTH / OUT_WIDTH;
  localparam int unsigned IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

  generate
    if (((IN_WIDTH % OUT_WIDTH) != 0) || (RATIO < 2)) begin : g_bad_ratio
      $error("width_downsizer: IN_WIDTH must be a multiple (>=2x) of OUT_WIDTH");
    end
  endgenerate

  typedef enum logic {
    EMPTY,
    SHIFTING
  } state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [IN_WIDTH-1:0]   word_q, word_d;

  logic                  in_fire;
  logic                  out_fire;
  logic [IDX_W-1:0]      sel;

  // Handshake outputs and chunk selection, all derived from the held state
  always_comb begin
    out_valid = (state_q == SHIFTING);
    out_last  = out_valid & (idx_q == LAST_IDX);
    busy      = out_valid;
    in_ready  = ~reset & ((state_q == EMPTY) | (out_last & out_ready));
    in_fire   = in_valid & in_ready;
    out_fire  = out_valid & out_ready;
    sel       = LSB_FIRST ? idx_q : (LAST_IDX - idx_q);
    out_data  = '0;
    for (int unsigned k = 0; k < RATIO; k++) begin
      if (out_valid && (sel == IDX_W'(k))) begin
        out_data = word_q[k*OUT_WIDTH +: OUT_WIDTH];
      end
    end
  end

  // Next-state: capture when empty, advance on accept, reload on last accept
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    word_d  = word_q;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          word_d  = in_data;
          idx_d   = '0;
          state_d = SHIFTING;
        end
      end
      SHIFTING: begin
        if (out_fire) begin
          if (out_last) begin
            idx_d = '0;
            if (in_fire) begin
              word_d  = in_data;
              state_d = SHIFTING;
            end else begin
              state_d = EMPTY;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = EMPTY;
        idx_d   = '0;
      end
    endcase
  end

  // State, index and holding register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      idx_q   <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
    end
  end

endmodule
